// File: rtl/arc4_stream.sv
// ARC4 stream-cipher core. The 256-byte S state is held in registers, so no
// external memory is needed. A start pulse runs the init and key-schedule
// passes, which take 512 cycles. After that, a valid/ready byte stream is
// XORed with the keystream at up to one byte per cycle.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | waiting for start; rdy=1, no stream traffic
// ST_INIT   | S[i]=i, one index per cycle (256 cycles)
// ST_KSA    | key schedule swap, one index per cycle (256 cycles)
// ST_STREAM | keyed; each accepted byte advances i/j and emits one result
module arc4_stream #(
  parameter int KEY_BYTES = 3,
  parameter int CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic                   rdy,
  output logic                   keyed,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [7:0]             out_data,
  input  logic                   out_ready,
  output logic [CNT_W-1:0]       byte_count
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_INIT,
    ST_KSA,
    ST_STREAM
  } state_t;

  state_t state, state_nxt;

  logic [7:0]             s_mem [256];
  logic [7:0]             idx_i;
  logic [7:0]             idx_j;
  logic [8*KEY_BYTES-1:0] key_sh;

  logic       start_ok;
  logic       take;
  logic [7:0] key_byte;
  logic [7:0] i_sel;
  logic [7:0] s_a;
  logic [7:0] j_new;
  logic [7:0] s_b;
  logic [7:0] t_idx;
  logic [7:0] ks_byte;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and handshake outputs
  always_comb begin
    state_nxt = state;
    rdy       = 1'b0;
    keyed     = 1'b0;
    in_ready  = 1'b0;
    start_ok  = 1'b0;
    case (state)
      ST_IDLE: begin
        rdy      = 1'b1;
        start_ok = start;
        if (start) state_nxt = ST_INIT;
      end
      ST_INIT: begin
        if (idx_i == 8'hFF) state_nxt = ST_KSA;
      end
      ST_KSA: begin
        if (idx_i == 8'hFF) state_nxt = ST_STREAM;
      end
      ST_STREAM: begin
        rdy      = 1'b1;
        keyed    = 1'b1;
        start_ok = start;
        // A re-key in the same cycle wins, so the input byte is left unconsumed
        in_ready = !start && (!out_valid || out_ready);
        if (start) state_nxt = ST_INIT;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Shared S read ports. KSA uses the current i; the stream step pre-increments i.
  // The key byte is added only during KSA.
  always_comb begin
    take     = in_valid && in_ready;
    key_byte = key_sh[8*KEY_BYTES-1 -: 8];
    i_sel    = (state == ST_KSA) ? idx_i : idx_i + 8'd1;
    s_a      = s_mem[i_sel];
    j_new    = idx_j + s_a + ((state == ST_KSA) ? key_byte : 8'h00);
    s_b      = s_mem[j_new];
    t_idx    = s_a + s_b;
    // Keystream byte is read from the post-swap S, so forward the two swapped entries
    if (t_idx == i_sel)      ks_byte = s_b;
    else if (t_idx == j_new) ks_byte = s_a;
    else                     ks_byte = s_mem[t_idx];
  end

  // S array: identity fill in INIT, swap in KSA and on every accepted stream byte
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      s_mem[idx_i] <= idx_i;
    end else if (state == ST_KSA || take) begin
      s_mem[i_sel] <= s_b;
      s_mem[j_new] <= s_a;
    end
  end

  // Index and key registers. The key rotates one byte per KSA step, so the top
  // byte is always key_byte[i mod KEY_BYTES].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_i  <= 8'h00;
      idx_j  <= 8'h00;
      key_sh <= '0;
    end else if (start_ok) begin
      idx_i  <= 8'h00;
      idx_j  <= 8'h00;
      key_sh <= key;
    end else begin
      case (state)
        ST_INIT: begin
          idx_i <= idx_i + 8'd1;
        end
        ST_KSA: begin
          idx_i  <= idx_i + 8'd1;
          idx_j  <= (idx_i == 8'hFF) ? 8'h00 : j_new;
          key_sh <= (key_sh << 8) | (key_sh >> (8*KEY_BYTES-8));
        end
        ST_STREAM: begin
          if (take) begin
            idx_i <= i_sel;
            idx_j <= j_new;
          end
        end
        default: ;
      endcase
    end
  end

  // Output register and byte counter. A re-key drops any pending result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= 8'h00;
      byte_count <= '0;
    end else if (start_ok) begin
      out_valid  <= 1'b0;
      byte_count <= '0;
    end else if (take) begin
      out_valid  <= 1'b1;
      out_data   <= in_data ^ ks_byte;
      byte_count <= byte_count + CNT_W'(1);
    end else if (out_valid && out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule
